// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg: shared UART types, data-length codes and decode helpers |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  // Code 2'b11 is a second encoding of "no parity".
  function automatic parity_e decode_parity(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return PAR_ODD;
      2'b10:   return PAR_EVEN;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic logic [3:0] data_bits_len(input logic [1:0] code);
    case (code)
      DBITS_5: return 4'd5;
      DBITS_6: return 4'd6;
      DBITS_7: return 4'd7;
      DBITS_8: return 4'd8;
      default: return 4'd8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_sync_fifo: single-clock FIFO with level, flush and flags     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module uart_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          pop_i,
  input  logic                          clr_i,
  output logic [DATA_W-1:0]             data_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          empty_o,
  output logic                          full_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(FIFO_DEPTH));
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && !full_o && !clr_i;
    do_pop   = pop_i && !empty_o && !clr_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_engine: buffered UART transmitter with runtime framing    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 16,
  parameter int IRQ_LVL    = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [DATA_W-1:0]           tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  input  logic [DIV_W-1:0]            cfg_divisor_i,
  input  logic [1:0]                  cfg_data_bits_i,
  input  logic [1:0]                  cfg_parity_i,
  input  logic                        cfg_stop2_i,
  input  logic                        cfg_break_i,
  input  logic                        cfg_irq_en_i,
  input  logic                        fifo_clr_i,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        fifo_empty_o,
  output logic                        fifo_full_o,
  output logic                        irq_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = DIV_W + $clog2(OVERSAMPLE);
  localparam logic [LVL_W-1:0] IRQ_THRESH = LVL_W'(IRQ_LVL);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        nbits_q, nbits_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              stop_idx_q, stop_idx_d;
  logic              tx_q, tx_d;
  logic              irq_q, irq_d;

  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_data;
  logic              can_pop;
  logic              cell_end;
  logic              load;
  logic              line_bit;
  logic [DIV_W-1:0]  cfg_div_eff;
  parity_e           cfg_par;
  logic [3:0]        cfg_nbits;
  logic [DATA_W-1:0] cfg_mask;
  logic              cfg_xor;

  function automatic logic [CNT_W-1:0] cell_reload(input logic [DIV_W-1:0] div);
    return CNT_W'(div) * CNT_W'(OVERSAMPLE) - CNT_W'(1);
  endfunction

  uart_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_valid_i),
    .data_i  (tx_data_i),
    .pop_i   (fifo_pop),
    .clr_i   (fifo_clr_i),
    .data_o  (fifo_data),
    .level_o (fifo_level_o),
    .empty_o (fifo_empty_o),
    .full_o  (fifo_full_o)
  );

  assign tx_ready_o = !fifo_full_o;
  assign busy_o     = (state_q != ST_IDLE);
  assign tx_o       = tx_q;
  assign irq_o      = irq_q;
  // A flush on the same edge suppresses the pop, so nothing new starts.
  assign can_pop    = !fifo_empty_o && !fifo_clr_i;

  always_comb begin
    cfg_div_eff = (cfg_divisor_i == '0) ? DIV_W'(1) : cfg_divisor_i;
    cfg_par     = decode_parity(cfg_parity_i);
    cfg_nbits   = data_bits_len(cfg_data_bits_i);
    cfg_mask    = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cfg_mask[i] = (i < int'(cfg_nbits));
    end
    cfg_xor = ^(fifo_data & cfg_mask);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    div_d      = div_q;
    nbits_d    = nbits_q;
    bit_idx_d  = bit_idx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    line_bit   = 1'b1;
    cell_end   = (cnt_q == '0);

    if (state_q != ST_IDLE && !cell_end) cnt_d = cnt_q - CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (can_pop) load = 1'b1;
      end
      ST_START: begin
        if (cell_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          cnt_d     = cell_reload(div_q);
        end
      end
      ST_DATA: begin
        if (cell_end) begin
          cnt_d = cell_reload(div_q);
          if (bit_idx_q == nbits_q - 4'd1) begin
            state_d    = par_en_q ? ST_PARITY : ST_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (cell_end) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
          cnt_d      = cell_reload(div_q);
        end
      end
      ST_STOP: begin
        if (cell_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            cnt_d      = cell_reload(div_q);
          end else if (can_pop) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Framing config is sampled only here, so mid-frame cfg changes wait for the next pop.
    if (load) begin
      fifo_pop  = 1'b1;
      state_d   = ST_START;
      shift_d   = fifo_data;
      div_d     = cfg_div_eff;
      nbits_d   = cfg_nbits;
      par_en_d  = (cfg_par != PAR_NONE);
      par_bit_d = (cfg_par == PAR_EVEN) ? cfg_xor : ~cfg_xor;
      stop2_d   = cfg_stop2_i;
      cnt_d     = cell_reload(cfg_div_eff);
    end

    case (state_d)
      ST_START:  line_bit = 1'b0;
      ST_DATA:   line_bit = shift_d[0];
      ST_PARITY: line_bit = par_bit_d;
      default:   line_bit = 1'b1;
    endcase

    tx_d  = cfg_break_i ? 1'b0 : line_bit;
    irq_d = cfg_irq_en_i && (fifo_level_o <= IRQ_THRESH);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      div_q      <= DIV_W'(1);
      nbits_q    <= 4'd8;
      bit_idx_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      nbits_q    <= nbits_d;
      bit_idx_q  <= bit_idx_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      irq_q      <= irq_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_tx_engine: directed self-checking bench for uart_tx_engine|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_uart_tx_engine;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] tx_data_i = '0;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [15:0] cfg_divisor_i = 16'd1;
  logic [1:0] cfg_data_bits_i = 2'b11;
  logic [1:0] cfg_parity_i = 2'b00;
  logic       cfg_stop2_i = 1'b0;
  logic       cfg_break_i = 1'b0;
  logic       cfg_irq_en_i = 1'b0;
  logic       fifo_clr_i = 1'b0;
  logic       tx_o;
  logic       busy_o;
  logic [4:0] fifo_level_o;
  logic       fifo_empty_o;
  logic       fifo_full_o;
  logic       irq_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  uart_tx_engine #(
    .DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16), .OVERSAMPLE(16), .IRQ_LVL(0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .cfg_divisor_i(cfg_divisor_i), .cfg_data_bits_i(cfg_data_bits_i),
    .cfg_parity_i(cfg_parity_i), .cfg_stop2_i(cfg_stop2_i),
    .cfg_break_i(cfg_break_i), .cfg_irq_en_i(cfg_irq_en_i),
    .fifo_clr_i(fifo_clr_i), .tx_o(tx_o), .busy_o(busy_o),
    .fifo_level_o(fifo_level_o), .fifo_empty_o(fifo_empty_o),
    .fifo_full_o(fifo_full_o), .irq_o(irq_o)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] word_of(input int i);
    return 8'(i * 59 + 7);
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    tick(2);
    tests++;
    if (tx_o !== 1'b1 || tx_ready_o !== 1'b1 || busy_o !== 1'b0 || fifo_level_o !== 5'd0 ||
        fifo_empty_o !== 1'b1 || fifo_full_o !== 1'b0 || irq_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: tx=%b rdy=%b busy=%b lvl=%0d emp=%b full=%b irq=%b, required 1 1 0 0 1 0 0",
               tx_o, tx_ready_o, busy_o, fifo_level_o, fifo_empty_o, fifo_full_o, irq_o);
    end
    rst_ni = 1'b1;
    tick(3);
    tests++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_level_o !== 5'd0) begin
      fails++;
      $display("FAIL after_reset_idle: tx=%b busy=%b lvl=%0d, required 1 0 0", tx_o, busy_o, fifo_level_o);
    end
  endtask

  // Pushes one word into an idle engine and checks every clock of the frame.
  task automatic check_frame(input string name, input logic [7:0] data, input logic [15:0] div,
                             input logic [1:0] bits, input logic [1:0] par, input logic stop2,
                             input logic [11:0] cells, input int ncells, input int cell_len);
    int bad_at;
    logic bad_tx, bad_busy;
    cfg_divisor_i = div; cfg_data_bits_i = bits; cfg_parity_i = par; cfg_stop2_i = stop2;
    tx_data_i = data; tx_valid_i = 1'b1;
    tick(1);
    tx_valid_i = 1'b0;
    tests++;
    if (tx_o !== 1'b1 || fifo_level_o !== 5'd1) begin
      fails++;
      $display("FAIL %s push_edge: tx=%b lvl=%0d, required tx=1 lvl=1", name, tx_o, fifo_level_o);
    end
    tick(1);
    tests++;
    if (fifo_level_o !== 5'd0 || busy_o !== 1'b1 || tx_o !== 1'b0) begin
      fails++;
      $display("FAIL %s pop_edge: lvl=%0d busy=%b tx=%b, required 0 1 0", name, fifo_level_o, busy_o, tx_o);
    end
    bad_at = -1; bad_tx = 1'b0; bad_busy = 1'b0;
    for (int c = 0; c < ncells; c++) begin
      for (int k = 0; k < cell_len; k++) begin
        if (bad_at < 0 && (tx_o !== cells[c] || busy_o !== 1'b1)) begin
          bad_at = c * cell_len + k; bad_tx = tx_o; bad_busy = busy_o;
        end
        tick(1);
      end
    end
    tests++;
    if (bad_at >= 0) begin
      fails++;
      $display("FAIL %s serial: clk %0d tx=%b busy=%b, required tx=%b busy=1",
               name, bad_at, bad_tx, bad_busy, cells[bad_at / cell_len]);
    end
    tests++;
    if (busy_o !== 1'b0 || tx_o !== 1'b1) begin
      fails++;
      $display("FAIL %s frame_end: busy=%b tx=%b, required busy=0 tx=1", name, busy_o, tx_o);
    end
  endtask

  task automatic test_frames();
    check_frame("8N1_A5", 8'hA5, 16'd1, 2'b11, 2'b00, 1'b0, 12'h34A, 10, 16);
    check_frame("7E2_55", 8'h55, 16'd2, 2'b10, 2'b10, 1'b1, 12'h6AA, 11, 32);
    check_frame("5O1_1F", 8'h1F, 16'd0, 2'b00, 2'b01, 1'b0, 12'h0BE, 8, 16);
    check_frame("6E1_C5", 8'hC5, 16'd1, 2'b01, 2'b10, 1'b0, 12'h10A, 9, 16);
  endtask

  task automatic test_irq();
    cfg_divisor_i = 16'd1; cfg_data_bits_i = 2'b11; cfg_parity_i = 2'b00; cfg_stop2_i = 1'b0;
    cfg_irq_en_i = 1'b1;
    tick(1);
    tests++;
    if (irq_o !== 1'b1) begin
      fails++; $display("FAIL irq_enable: irq=%b, required 1", irq_o);
    end
    tx_data_i = 8'h00; tx_valid_i = 1'b1;
    tick(1);
    tx_valid_i = 1'b0;
    tests++;
    if (irq_o !== 1'b1 || fifo_level_o !== 5'd1) begin
      fails++; $display("FAIL irq_push_edge: irq=%b lvl=%0d, required irq=1 lvl=1", irq_o, fifo_level_o);
    end
    tick(1);
    tests++;
    if (irq_o !== 1'b0) begin
      fails++; $display("FAIL irq_after_push: irq=%b, required 0", irq_o);
    end
    tick(1);
    tests++;
    if (irq_o !== 1'b1) begin
      fails++; $display("FAIL irq_level_zero: irq=%b, required 1", irq_o);
    end
    tick(170);
    cfg_irq_en_i = 1'b0;
    tick(1);
    tests++;
    if (irq_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL irq_disable: irq=%b busy=%b, required 0 0", irq_o, busy_o);
    end
  endtask

  task automatic test_clear();
    int cnt;
    for (int i = 0; i < 6; i++) begin
      tx_data_i = 8'(8'h3C + i); tx_valid_i = 1'b1;
      tick(1);
    end
    tx_valid_i = 1'b0;
    tests++;
    if (fifo_level_o !== 5'd5) begin
      fails++; $display("FAIL clr_prefill: lvl=%0d, required 5", fifo_level_o);
    end
    fifo_clr_i = 1'b1;
    tick(1);
    fifo_clr_i = 1'b0;
    tests++;
    if (fifo_level_o !== 5'd0 || fifo_empty_o !== 1'b1 || busy_o !== 1'b1) begin
      fails++; $display("FAIL clr_flush: lvl=%0d emp=%b busy=%b, required 0 1 1", fifo_level_o, fifo_empty_o, busy_o);
    end
    cnt = 0;
    while (busy_o && cnt < 400) begin
      tick(1); cnt++;
    end
    tests++;
    if (cnt != 155) begin
      fails++; $display("FAIL clr_frame_finish: busy dropped after %0d clk, required 155", cnt);
    end
    tick(40);
    tests++;
    if (busy_o !== 1'b0 || tx_o !== 1'b1 || fifo_level_o !== 5'd0) begin
      fails++; $display("FAIL clr_no_more: busy=%b tx=%b lvl=%0d, required 0 1 0", busy_o, tx_o, fifo_level_o);
    end
  endtask

  task automatic test_break();
    logic bad;
    tx_data_i = 8'hFF; tx_valid_i = 1'b1;
    tick(1);
    tx_valid_i = 1'b0;
    tick(20);
    tests++;
    if (tx_o !== 1'b1) begin
      fails++; $display("FAIL brk_pre: tx=%b, required 1", tx_o);
    end
    cfg_break_i = 1'b1;
    tick(1);
    tests++;
    if (tx_o !== 1'b0) begin
      fails++; $display("FAIL brk_assert: tx=%b, required 0", tx_o);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tx_o !== 1'b0 || busy_o !== 1'b1) bad = 1'b1;
      tick(1);
    end
    tests++;
    if (bad) begin
      fails++; $display("FAIL brk_hold: line or busy wrong during break, got bad=%b, required 0", bad);
    end
    cfg_break_i = 1'b0;
    tick(1);
    tests++;
    if (tx_o !== 1'b1) begin
      fails++; $display("FAIL brk_release: tx=%b, required 1", tx_o);
    end
    tick(140);
    tests++;
    if (busy_o !== 1'b0) begin
      fails++; $display("FAIL brk_frame_end: busy=%b, required 0", busy_o);
    end
  endtask

  task automatic test_reset_midframe();
    tx_data_i = 8'h00; tx_valid_i = 1'b1;
    tick(1);
    tx_data_i = 8'h12;
    tick(1);
    tx_valid_i = 1'b0;
    tick(20);
    tests++;
    if (tx_o !== 1'b0 || fifo_level_o !== 5'd1) begin
      fails++; $display("FAIL rst_pre: tx=%b lvl=%0d, required tx=0 lvl=1", tx_o, fifo_level_o);
    end
    rst_ni = 1'b0;
    #1;
    tests++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_level_o !== 5'd0 || tx_ready_o !== 1'b1) begin
      fails++; $display("FAIL rst_async: tx=%b busy=%b lvl=%0d rdy=%b, required 1 0 0 1",
                        tx_o, busy_o, fifo_level_o, tx_ready_o);
    end
    tick(2);
    rst_ni = 1'b1;
    tick(5);
    tests++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_empty_o !== 1'b1) begin
      fails++; $display("FAIL rst_release: tx=%b busy=%b emp=%b, required 1 0 1", tx_o, busy_o, fifo_empty_o);
    end
  endtask

  task automatic decode(input int first_wait, input int step, output logic [9:0] raw);
    tick(first_wait);
    for (int c = 0; c < 10; c++) begin
      raw[c] = tx_o;
      if (c != 9) tick(step);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] raw;
    logic [9:0] exp_raw;
    cfg_divisor_i = 16'd100; cfg_data_bits_i = 2'b11; cfg_parity_i = 2'b00; cfg_stop2_i = 1'b0;
    tx_data_i = 8'h81; tx_valid_i = 1'b1;
    tick(1);
    tx_valid_i = 1'b0;
    tick(1);
    tests++;
    if (busy_o !== 1'b1 || fifo_level_o !== 5'd0) begin
      fails++; $display("FAIL b2b_first_pop: busy=%b lvl=%0d, required 1 0", busy_o, fifo_level_o);
    end
    for (int i = 1; i <= 16; i++) begin
      tx_data_i = word_of(i); tx_valid_i = 1'b1;
      tick(1);
    end
    tests++;
    if (fifo_level_o !== 5'd16 || fifo_full_o !== 1'b1 || tx_ready_o !== 1'b0) begin
      fails++; $display("FAIL b2b_full: lvl=%0d full=%b rdy=%b, required 16 1 0", fifo_level_o, fifo_full_o, tx_ready_o);
    end
    tx_data_i = 8'hEE;
    tick(1);
    tx_valid_i = 1'b0;
    cfg_divisor_i = 16'd1;
    tests++;
    if (fifo_level_o !== 5'd16) begin
      fails++; $display("FAIL b2b_refused: lvl=%0d, required 16", fifo_level_o);
    end
    decode(783, 1600, raw);
    exp_raw = {1'b1, 8'h81, 1'b0};
    tests++;
    if (raw !== exp_raw) begin
      fails++; $display("FAIL b2b_frame0: got %h, required %h", raw, exp_raw);
    end
    tests++;
    if (tx_ready_o !== 1'b0 || fifo_level_o !== 5'd16) begin
      fails++; $display("FAIL b2b_still_full: rdy=%b lvl=%0d, required 0 16", tx_ready_o, fifo_level_o);
    end
    for (int i = 1; i <= 16; i++) begin
      decode((i == 1) ? 808 : 16, 16, raw);
      exp_raw = {1'b1, word_of(i), 1'b0};
      tests++;
      if (raw !== exp_raw) begin
        fails++; $display("FAIL b2b_frame%0d: got %h, required %h", i, raw, exp_raw);
      end
    end
    tick(8);
    tests++;
    if (busy_o !== 1'b0 || fifo_empty_o !== 1'b1 || tx_o !== 1'b1) begin
      fails++; $display("FAIL b2b_done: busy=%b emp=%b tx=%b, required 0 1 1", busy_o, fifo_empty_o, tx_o);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frames();
    test_irq();
    test_clear();
    test_break();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
